// File: rtl/ad9226_capture_buffer.sv
// Triggered capture buffer for the AD9226 driver stage: arm, level-crossing trigger, DEPTH-sample
// capture into on-chip RAM, then valid/ready readout. ADC_CAP_AUTOTRIG_EN enables the ARMED timeout.
module ad9226_capture_buffer #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_adc_clk,
    input  logic [12:0] i_adc_data,
    input  logic        i_arm,
    input  logic        i_force,
    input  logic        i_abort,
    input  logic [11:0] i_trig_level,
    output logic [11:0] o_data,
    output logic        o_otr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_otr_seen,
    output logic [1:0]  o_state
);

    if (DEPTH != (1 << ADDR_W) || DEPTH < 4 || TIMEOUT == 0) begin : g_param_check
        $error("ad9226_capture_buffer: DEPTH must be 2**ADDR_W and >= 4, TIMEOUT must be > 0");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StReadout = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e             state_q;
    logic               adc_clk_q;
    logic [11:0]        prev_q;
    logic               prev_valid_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [12:0]        mem [DEPTH];

    logic               stb;
    logic [11:0]        cur;
    logic               level_hit;
    logic               timeout_hit;
    logic               trig;
    logic               we;
    logic [ADDR_W-1:0]  waddr;

`ifdef ADC_CAP_AUTOTRIG_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] tmo_q;
    assign timeout_hit = (tmo_q == CntW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign stb = i_adc_clk & ~adc_clk_q;
    assign cur = {~i_adc_data[11], i_adc_data[10:0]};

    // A level trigger needs a previous sample from this arming; the first strobe only loads it.
    assign level_hit = prev_valid_q && ($signed(prev_q) < $signed(i_trig_level))
                       && ($signed(cur) >= $signed(i_trig_level));
    assign trig      = i_force | level_hit | timeout_hit;

    assign we    = ~sys_rst & ~i_abort & stb
                   & (((state_q == StArmed) & trig) | (state_q == StCapture));
    assign waddr = (state_q == StCapture) ? wr_ptr_q : '0;

    assign o_state = state_q;
    assign o_busy  = (state_q != StIdle);

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= {i_adc_data[12], cur};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            adc_clk_q    <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            o_data       <= '0;
            o_otr        <= 1'b0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;
            o_otr_seen   <= 1'b0;
`ifdef ADC_CAP_AUTOTRIG_EN
            tmo_q        <= '0;
`endif
        end else begin
            adc_clk_q <= i_adc_clk;
            o_done    <= 1'b0;
            if (i_abort) begin
                state_q <= StIdle;
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (i_arm) begin
                            state_q      <= StArmed;
                            o_otr_seen   <= 1'b0;
                            wr_ptr_q     <= '0;
                            prev_valid_q <= 1'b0;
`ifdef ADC_CAP_AUTOTRIG_EN
                            tmo_q        <= '0;
`endif
                        end
                    end
                    StArmed: begin
                        if (stb) begin
                            prev_q       <= cur;
                            prev_valid_q <= 1'b1;
`ifdef ADC_CAP_AUTOTRIG_EN
                            tmo_q        <= tmo_q + 1'b1;
`endif
                            if (trig) begin
                                state_q    <= StCapture;
                                wr_ptr_q   <= ADDR_W'(1);
                                o_otr_seen <= o_otr_seen | i_adc_data[12];
                            end
                        end
                    end
                    StCapture: begin
                        if (stb) begin
                            wr_ptr_q   <= wr_ptr_q + 1'b1;
                            o_otr_seen <= o_otr_seen | i_adc_data[12];
                            if (wr_ptr_q == LastAddr) begin
                                state_q  <= StReadout;
                                rd_ptr_q <= '0;
                            end
                        end
                    end
                    StReadout: begin
                        // Output register doubles as the RAM read register: load whenever it is
                        // empty or being drained, unless the final beat is already presented.
                        if (o_valid && o_last && i_ready) begin
                            state_q <= StIdle;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_done  <= 1'b1;
                        end else if (!o_valid || (i_ready && !o_last)) begin
                            {o_otr, o_data} <= mem[rd_ptr_q];
                            o_valid         <= 1'b1;
                            o_last          <= (rd_ptr_q == LastAddr);
                            rd_ptr_q        <= rd_ptr_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad9226_capture_buffer.sv
// Self-checking bench for ad9226_capture_buffer: table of capture scenarios checked through a
// sample scoreboard, plus hand sequences for abort, reset, ignored arm and auto-trigger.
module tb_ad9226_capture_buffer;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TOUT   = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        i_adc_clk;
    logic [12:0] i_adc_data;
    logic        i_arm;
    logic        i_force;
    logic        i_abort;
    logic [11:0] i_trig_level;
    logic [11:0] o_data;
    logic        o_otr;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
    logic        o_otr_seen;
    logic [1:0]  o_state;

    ad9226_capture_buffer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .i_adc_clk    (i_adc_clk),
        .i_adc_data   (i_adc_data),
        .i_arm        (i_arm),
        .i_force      (i_force),
        .i_abort      (i_abort),
        .i_trig_level (i_trig_level),
        .o_data       (o_data),
        .o_otr        (o_otr),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_otr_seen   (o_otr_seen),
        .o_state      (o_state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          pat;        // 0 = ramp, 1 = constant 0x7FF
        logic        frc;
        logic [11:0] lvl;
        int          rmode;      // 0 = ready held high, 1 = random ready
        int          otr_idx;    // sample index carrying OTR, -1 for none
        logic [11:0] exp_first;
        logic        exp_seen;
    } vec_t;

    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [12:0] sb [$];

    // Reference model of the trigger/capture decision
    int          m_st;
    logic        m_pv;
    logic [11:0] m_prev;
    logic [11:0] m_lvl;
    logic        m_frc;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [11:0] pat_data(input int pat, input int n);
        return (pat == 0) ? 12'(n) : 12'h7FF;
    endfunction

    task automatic model_stb(input logic [11:0] conv, input logic otr);
        if (m_st == 1) begin
            if (m_frc || (m_pv && ($signed(m_prev) < $signed(m_lvl))
                          && ($signed(conv) >= $signed(m_lvl)))) begin
                m_st  = 2;
                m_cnt = 0;
            end
            m_prev = conv;
            m_pv   = 1'b1;
        end
        if (m_st == 2) begin
            sb.push_back({otr, conv});
            m_cnt++;
            if (m_cnt == DEPTH) m_st = 3;
        end
    endtask

    task automatic feed_stb(input logic [11:0] d, input logic otr);
        i_adc_data = {otr, d};
        i_adc_clk  = 1'b1;
        model_stb({~d[11], d[10:0]}, otr);
        tick();
        tick();
        i_adc_clk = 1'b0;
        tick();
        tick();
    endtask

    task automatic model_arm(input logic frc, input logic [11:0] lvl);
        sb.delete();
        m_st  = 1;
        m_pv  = 1'b0;
        m_frc = frc;
        m_lvl = lvl;
        m_cnt = 0;
    endtask

    task automatic pulse_arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    task automatic drain(input int rmode, input logic [11:0] exp_first, input logic exp_seen);
        int          beat    = 0;
        int          budget  = 0;
        int          done0   = done_cnt;
        logic        stalled = 1'b0;
        logic        rdy;
        logic [11:0] held_d  = '0;
        logic        held_o  = 1'b0;
        logic        held_l  = 1'b0;
        logic [12:0] exp;
        while (beat < DEPTH && budget < 20000) begin
            tick();
            budget++;
            if (stalled) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, held_d);
                check("stall_otr", o_otr, held_o);
                check("stall_last", o_last, held_l);
            end
            rdy     = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_ready = rdy;
            if (o_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", beat, DEPTH);
                    exp = '0;
                end else begin
                    exp = sb.pop_front();
                end
                check("beat_data", o_data, exp[11:0]);
                check("beat_otr", o_otr, exp[12]);
                check("beat_last", o_last, beat == DEPTH - 1);
                if (beat == 0) check("first_sample", o_data, exp_first);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = o_valid;
                held_d  = o_data;
                held_o  = o_otr;
                held_l  = o_last;
            end
        end
        if (beat < DEPTH) check("drain_timeout", beat, DEPTH);
        tick();
        i_ready = 1'b0;
        check("end_valid", o_valid, 0);
        check("end_last", o_last, 0);
        check("end_done", o_done, 1);
        check("end_state", o_state, 0);
        tick();
        check("done_pulse_width", o_done, 0);
        check("done_count", done_cnt - done0, 1);
        check("otr_seen", o_otr_seen, exp_seen);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic run_case(input vec_t v);
        int n = 0;
        model_arm(v.frc, v.lvl);
        i_trig_level = v.lvl;
        i_force      = v.frc;
        i_ready      = 1'b0;
        pulse_arm();
        check("arm_state", o_state, 1);
        check("arm_clears_otr_seen", o_otr_seen, 0);
        while (m_st != 3 && n < 4096) begin
            feed_stb(pat_data(v.pat, n), (m_st == 2) && (m_cnt == v.otr_idx));
            n++;
        end
        i_force = 1'b0;
        check("capture_complete", m_st, 3);
        check("readout_state", o_state, 3);
        drain(v.rmode, v.exp_first, v.exp_seen);
        m_st = 0;
    endtask

    // Per-cycle monitor: busy tracks state, readout valid latency, o_done pulse count
    logic [1:0] mon_prev_st = 2'd0;
    int         mon_lat     = 0;
    logic       mon_lat_ok  = 1'b0;
    always @(posedge sys_clk) begin
        #1;
        if (o_done) done_cnt++;
        check("busy_vs_state", o_busy, o_state != 2'd0);
        if (o_state == 2'd3) begin
            if (mon_prev_st != 2'd3) begin
                mon_lat    = 0;
                mon_lat_ok = 1'b0;
            end else begin
                mon_lat++;
            end
            if (o_valid && !mon_lat_ok) begin
                check("valid_latency", mon_lat <= 2, 1);
                mon_lat_ok = 1'b1;
            end
        end
        mon_prev_st = o_state;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp8;
        vecs[0] = '{0, 1'b0, 12'h000, 0, -1, 12'h000, 1'b0};
        vecs[1] = '{1, 1'b1, 12'h000, 0, -1, 12'hFFF, 1'b0};
        vecs[2] = '{0, 1'b1, 12'h000, 1, -1, 12'h800, 1'b0};
        vecs[3] = '{0, 1'b0, 12'hF00, 1, -1, 12'hF00, 1'b0};
        vecs[4] = '{0, 1'b1, 12'h000, 0, 17, 12'h800, 1'b1};
        m_st = 0;

        sys_rst      = 1'b1;
        i_adc_clk    = 1'b0;
        i_adc_data   = '0;
        i_arm        = 1'b0;
        i_force      = 1'b0;
        i_abort      = 1'b0;
        i_trig_level = '0;
        i_ready      = 1'b0;
        repeat (3) tick();
        check("rst_state", o_state, 0);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_done", o_done, 0);
        check("rst_otr_seen", o_otr_seen, 0);
        check("rst_busy", o_busy, 0);
        check("rst_data", o_data, 0);
        check("rst_otr", o_otr, 0);
        sys_rst = 1'b0;
        tick();
        check("post_rst_state", o_state, 0);

        for (int i = 0; i < 5; i++) run_case(vecs[i]);

        // Abort at wr_ptr=300 with an OTR sample already stored
        model_arm(1'b1, 12'h000);
        i_force = 1'b1;
        pulse_arm();
        check("abort_arm_clears_otr_seen", o_otr_seen, 0);
        n = 0;
        while (m_cnt < 300 && n < 1000) begin
            feed_stb(12'h123, n == 5);
            n++;
        end
        i_force = 1'b0;
        check("abort_pre_state", o_state, 2);
        n = done_cnt;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_state", o_state, 0);
        check("abort_valid", o_valid, 0);
        check("abort_last", o_last, 0);
        check("abort_keeps_otr_seen", o_otr_seen, 1);
        for (int i = 0; i < 4; i++) feed_stb(12'h123, 1'b0);
        check("abort_still_idle", o_state, 0);
        check("abort_no_valid", o_valid, 0);
        check("abort_no_done", done_cnt - n, 0);
        m_st = 0;
        run_case(vecs[1]);

        // i_arm in ARMED must not clear the previous sample; then reset during READOUT
        model_arm(1'b0, 12'h000);
        i_trig_level = 12'h000;
        pulse_arm();
        feed_stb(12'h000, 1'b0);
        feed_stb(12'h7FF, 1'b0);
        check("armed_no_trigger", o_state, 1);
        pulse_arm();
        check("arm_ignored_armed", o_state, 1);
        feed_stb(12'h800, 1'b0);
        check("trigger_after_ignored_arm", o_state, 2);
        n = 0;
        while (m_st != 3 && n < 2000) begin
            feed_stb(12'h123, 1'b1);
            n++;
        end
        check("rst_seq_readout", o_state, 3);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        check("rst_seq_beat1_data", o_data, 12'h923);
        check("rst_seq_beat1_otr", o_otr, 1);
        sys_rst = 1'b1;
        tick();
        check("rdrst_state", o_state, 0);
        check("rdrst_valid", o_valid, 0);
        check("rdrst_last", o_last, 0);
        check("rdrst_done", o_done, 0);
        check("rdrst_otr_seen", o_otr_seen, 0);
        check("rdrst_busy", o_busy, 0);
        check("rdrst_data", o_data, 0);
        check("rdrst_otr", o_otr, 0);
        sys_rst = 1'b0;
        sb.delete();
        m_st = 0;
        tick();

        // Flat input below the level: auto-trigger on the TOUT-th strobe only when enabled
`ifdef ADC_CAP_AUTOTRIG_EN
        exp8 = 2'd2;
`else
        exp8 = 2'd1;
`endif
        i_trig_level = 12'h000;
        pulse_arm();
        for (int i = 0; i < TOUT - 1; i++) feed_stb(12'h000, 1'b0);
        check("autotrig_before_timeout", o_state, 1);
        feed_stb(12'h000, 1'b0);
        check("autotrig_at_timeout", o_state, exp8);
        for (int i = 0; i < 4; i++) feed_stb(12'h000, 1'b0);
        check("autotrig_after_timeout", o_state, exp8);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("final_abort_state", o_state, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
